// File: rtl/victim_sel_lv2_if.sv
// Bus bundle between the L2 miss-allocation controller and its neighbours
// (miss handler, pseudo-LRU block, writeback path).
`ifndef ASSOC_WID_LV2
`define ASSOC_WID_LV2 3
`endif
`ifndef INDEX_MSB_LV2
`define INDEX_MSB_LV2 15
`endif
`ifndef INDEX_LSB_LV2
`define INDEX_LSB_LV2 6
`endif

interface victim_sel_lv2_if #(
   parameter int ASSOC     = 8,
   parameter int ASSOC_WID = `ASSOC_WID_LV2,
   parameter int INDEX_MSB = `INDEX_MSB_LV2,
   parameter int INDEX_LSB = `INDEX_LSB_LV2
);
   logic                       miss_req;
   logic [INDEX_MSB:INDEX_LSB] miss_index;
   logic                       miss_ack;
   logic                       busy;
   logic [INDEX_MSB:INDEX_LSB] index_proc;
   logic [ASSOC_WID-1:0]       lru_replacement_proc;
   logic [ASSOC-1:0]           way_valid;
   logic [ASSOC-1:0]           way_dirty;
   logic                       wb_req;
   logic [ASSOC_WID-1:0]       wb_way;
   logic                       wb_ack;
   logic                       alloc_valid;
   logic [ASSOC_WID-1:0]       alloc_way;
   logic [ASSOC_WID-1:0]       blk_accessed_main;

   // Controller side.
   modport master (
      input  miss_req, miss_index, lru_replacement_proc, way_valid, way_dirty, wb_ack,
      output miss_ack, busy, index_proc, wb_req, wb_way, alloc_valid, alloc_way,
             blk_accessed_main
   );

   // Miss handler / LRU block / writeback side.
   modport slave (
      output miss_req, miss_index, lru_replacement_proc, way_valid, way_dirty, wb_ack,
      input  miss_ack, busy, index_proc, wb_req, wb_way, alloc_valid, alloc_way,
             blk_accessed_main
   );
endinterface

// File: rtl/victim_sel_lv2.sv
// L2 miss-allocation controller: picks a victim way, writes it back if dirty, grants the fill way.
// Optional feature macro INVALID_WAY_FIRST_EN: prefer the lowest-numbered invalid way over the LRU way.
`ifndef ASSOC_WID_LV2
`define ASSOC_WID_LV2 3
`endif
`ifndef INDEX_MSB_LV2
`define INDEX_MSB_LV2 15
`endif
`ifndef INDEX_LSB_LV2
`define INDEX_LSB_LV2 6
`endif

module victim_sel_lv2 #(
   parameter int ASSOC     = 8,
   parameter int ASSOC_WID = `ASSOC_WID_LV2,
   parameter int INDEX_MSB = `INDEX_MSB_LV2,
   parameter int INDEX_LSB = `INDEX_LSB_LV2
) (
   input  logic             clk,
   input  logic             rst_b,
   victim_sel_lv2_if.master bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SELECT  = 2'd1,
      WB_WAIT = 2'd2,
      ALLOC   = 2'd3
   } state_t;

   state_t                     state_r;
   state_t                     next_state_s;
   logic [ASSOC_WID-1:0]       victim_s;
   logic                       wb_needed_s;
   logic [ASSOC_WID-1:0]       victim_r;
   logic [INDEX_MSB:INDEX_LSB] index_proc_r;
   logic                       miss_ack_r;
   logic                       busy_r;
   logic                       wb_req_r;
   logic [ASSOC_WID-1:0]       wb_way_r;
   logic                       alloc_valid_r;
   logic [ASSOC_WID-1:0]       alloc_way_r;
   logic [ASSOC_WID-1:0]       blk_accessed_main_r;

`ifdef INVALID_WAY_FIRST_EN
   function automatic logic [ASSOC_WID-1:0] first_invalid(input logic [ASSOC-1:0] valid);
      logic [ASSOC_WID-1:0] idx;
      idx = '0;
      for (int i = ASSOC - 1; i >= 0; i--) begin
         if (!valid[i]) begin
            idx = ASSOC_WID'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction
`endif

   // Victim choice and writeback decision, meaningful only while in SELECT.
   always_comb begin
      victim_s = bus.lru_replacement_proc;
`ifdef INVALID_WAY_FIRST_EN
      if (!(&bus.way_valid)) begin
         victim_s = first_invalid(bus.way_valid);
      end else begin
         victim_s = bus.lru_replacement_proc;
      end
`endif
      wb_needed_s = bus.way_valid[victim_s] & bus.way_dirty[victim_s];
   end

   // State register.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.miss_req) begin
               next_state_s = SELECT;
            end else begin
               next_state_s = IDLE;
            end
         end
         SELECT: begin
            if (wb_needed_s) begin
               next_state_s = WB_WAIT;
            end else begin
               next_state_s = ALLOC;
            end
         end
         WB_WAIT: begin
            if (bus.wb_ack) begin
               next_state_s = ALLOC;
            end else begin
               next_state_s = WB_WAIT;
            end
         end
         ALLOC:   next_state_s = IDLE;
         default: next_state_s = IDLE;
      endcase
   end

   // Status and handshake outputs are registered off the next state so they line up with it.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         busy_r        <= 1'b0;
         wb_req_r      <= 1'b0;
         alloc_valid_r <= 1'b0;
         miss_ack_r    <= 1'b0;
      end else begin
         busy_r        <= (next_state_s != IDLE);
         wb_req_r      <= (next_state_s == WB_WAIT);
         alloc_valid_r <= (next_state_s == ALLOC);
         miss_ack_r    <= (next_state_s == ALLOC);
      end
   end

   // Index, victim and way registers.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         index_proc_r        <= '0;
         victim_r            <= '0;
         wb_way_r            <= '0;
         alloc_way_r         <= '0;
         blk_accessed_main_r <= '0;
      end else begin
         if ((state_r == IDLE) && bus.miss_req) begin
            index_proc_r <= bus.miss_index;
         end
         if (state_r == SELECT) begin
            victim_r <= victim_s;
            if (wb_needed_s) begin
               wb_way_r <= victim_s;
            end
         end
         // From SELECT the victim is still combinational; from WB_WAIT it has been captured.
         if (next_state_s == ALLOC) begin
            if (state_r == SELECT) begin
               alloc_way_r <= victim_s;
            end else begin
               alloc_way_r <= victim_r;
            end
         end
         if (state_r == ALLOC) begin
            blk_accessed_main_r <= alloc_way_r;
         end
      end
   end

   assign bus.index_proc        = index_proc_r;
   assign bus.miss_ack          = miss_ack_r;
   assign bus.busy              = busy_r;
   assign bus.wb_req            = wb_req_r;
   assign bus.wb_way            = wb_way_r;
   assign bus.alloc_valid       = alloc_valid_r;
   assign bus.alloc_way         = alloc_way_r;
   assign bus.blk_accessed_main = blk_accessed_main_r;

endmodule

// File: tb/tb_victim_sel_lv2.sv
// Directed bench for victim_sel_lv2: allocations are scoreboarded, timing points checked inline.
module tb_victim_sel_lv2;

   logic clk;
   logic rst_b;
   int   n_total;
   int   n_pass;

   typedef struct {
      logic [2:0] way;
      logic [9:0] idx;
   } exp_t;

   exp_t sb_q[$];

   victim_sel_lv2_if bus_if ();

   victim_sel_lv2 u_dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] way, input logic [9:0] idx);
      exp_t e;
      e.way = way;
      e.idx = idx;
      sb_q.push_back(e);
   endtask

   // Every grant is matched against the oldest expected allocation.
   always @(negedge clk) begin
      exp_t e;
      if (bus_if.alloc_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_alloc", 32'd1, 32'd0);
         end else begin
            e = sb_q.pop_front();
            chk("alloc_way", 32'(bus_if.alloc_way), 32'(e.way));
            chk("alloc_index", 32'(bus_if.index_proc), 32'(e.idx));
            chk("alloc_miss_ack", 32'(bus_if.miss_ack), 32'd1);
         end
      end
   end

   initial begin
      logic [2:0] inv_exp;
      n_total = 0;
      n_pass  = 0;
      rst_b   = 1'b0;
      bus_if.miss_req             = 1'b0;
      bus_if.miss_index           = 10'h000;
      bus_if.lru_replacement_proc = 3'd0;
      bus_if.way_valid            = 8'hFF;
      bus_if.way_dirty            = 8'h00;
      bus_if.wb_ack               = 1'b0;
      step();
      step();
      chk("rst_busy", 32'(bus_if.busy), 32'd0);
      chk("rst_wb_req", 32'(bus_if.wb_req), 32'd0);
      chk("rst_alloc_valid", 32'(bus_if.alloc_valid), 32'd0);
      chk("rst_miss_ack", 32'(bus_if.miss_ack), 32'd0);
      chk("rst_index_proc", 32'(bus_if.index_proc), 32'd0);
      chk("rst_wb_way", 32'(bus_if.wb_way), 32'd0);
      chk("rst_alloc_way", 32'(bus_if.alloc_way), 32'd0);
      chk("rst_blk", 32'(bus_if.blk_accessed_main), 32'd0);
      rst_b = 1'b1;
      step();

      // Clean victim: grant two cycles after the request.
      bus_if.lru_replacement_proc = 3'd5;
      bus_if.miss_index = 10'h12A;
      bus_if.miss_req   = 1'b1;
      push(3'd5, 10'h12A);
      step();
      chk("clean_c1_busy", 32'(bus_if.busy), 32'd1);
      chk("clean_c1_index", 32'(bus_if.index_proc), 32'h12A);
      chk("clean_c1_alloc_valid", 32'(bus_if.alloc_valid), 32'd0);
      step();
      chk("clean_c2_alloc_valid", 32'(bus_if.alloc_valid), 32'd1);
      chk("clean_c2_wb_req", 32'(bus_if.wb_req), 32'd0);
      chk("clean_c2_busy", 32'(bus_if.busy), 32'd1);
      bus_if.miss_req = 1'b0;
      step();
      chk("clean_c3_blk", 32'(bus_if.blk_accessed_main), 32'd5);
      chk("clean_c3_alloc_valid", 32'(bus_if.alloc_valid), 32'd0);
      chk("clean_c3_miss_ack", 32'(bus_if.miss_ack), 32'd0);
      chk("clean_c3_busy", 32'(bus_if.busy), 32'd0);
      step();
      chk("clean_blk_hold", 32'(bus_if.blk_accessed_main), 32'd5);

      // Way 3 invalid (its dirty bit set too) with LRU pointing at way 6.
`ifdef INVALID_WAY_FIRST_EN
      inv_exp = 3'd3;
`else
      inv_exp = 3'd6;
`endif
      bus_if.way_valid = 8'hF7;
      bus_if.way_dirty = 8'h08;
      bus_if.lru_replacement_proc = 3'd6;
      bus_if.miss_index = 10'h055;
      bus_if.miss_req   = 1'b1;
      push(inv_exp, 10'h055);
      step();
      step();
      chk("inv_c2_alloc_valid", 32'(bus_if.alloc_valid), 32'd1);
      chk("inv_c2_wb_req", 32'(bus_if.wb_req), 32'd0);
      bus_if.miss_req = 1'b0;
      step();
      chk("inv_c3_blk", 32'(bus_if.blk_accessed_main), 32'(inv_exp));
      step();

      // LRU points at an invalid way whose dirty bit is set: no writeback in either build.
      bus_if.lru_replacement_proc = 3'd3;
      bus_if.miss_index = 10'h056;
      bus_if.miss_req   = 1'b1;
      push(3'd3, 10'h056);
      step();
      step();
      chk("lruinv_c2_alloc_valid", 32'(bus_if.alloc_valid), 32'd1);
      chk("lruinv_c2_wb_req", 32'(bus_if.wb_req), 32'd0);
      bus_if.miss_req = 1'b0;
      step();
      step();

      // Dirty victim way 2, writeback acknowledged in c5.
      bus_if.way_valid = 8'hFF;
      bus_if.way_dirty = 8'h04;
      bus_if.lru_replacement_proc = 3'd2;
      bus_if.miss_index = 10'h3C0;
      bus_if.miss_req   = 1'b1;
      push(3'd2, 10'h3C0);
      step();
      chk("dirty_c1_wb_req", 32'(bus_if.wb_req), 32'd0);
      step();
      chk("dirty_c2_wb_req", 32'(bus_if.wb_req), 32'd1);
      chk("dirty_c2_wb_way", 32'(bus_if.wb_way), 32'd2);
      chk("dirty_c2_alloc_valid", 32'(bus_if.alloc_valid), 32'd0);
      bus_if.miss_req = 1'b0;
      bus_if.lru_replacement_proc = 3'd7;
      bus_if.way_dirty = 8'h00;
      step();
      step();
      chk("dirty_c4_wb_req", 32'(bus_if.wb_req), 32'd1);
      chk("dirty_c4_busy", 32'(bus_if.busy), 32'd1);
      step();
      chk("dirty_c5_wb_req", 32'(bus_if.wb_req), 32'd1);
      chk("dirty_c5_wb_way", 32'(bus_if.wb_way), 32'd2);
      bus_if.wb_ack = 1'b1;
      step();
      chk("dirty_c6_wb_req", 32'(bus_if.wb_req), 32'd0);
      chk("dirty_c6_alloc_valid", 32'(bus_if.alloc_valid), 32'd1);
      bus_if.wb_ack = 1'b0;
      step();
      chk("dirty_c7_blk", 32'(bus_if.blk_accessed_main), 32'd2);
      chk("dirty_c7_busy", 32'(bus_if.busy), 32'd0);

      // wb_ack in IDLE is ignored, then held high through a dirty miss on way 7.
      bus_if.wb_ack = 1'b1;
      step();
      step();
      chk("idle_ack_busy", 32'(bus_if.busy), 32'd0);
      chk("idle_ack_wb_req", 32'(bus_if.wb_req), 32'd0);
      bus_if.way_dirty = 8'h80;
      bus_if.lru_replacement_proc = 3'd7;
      bus_if.miss_index = 10'h201;
      bus_if.miss_req   = 1'b1;
      push(3'd7, 10'h201);
      step();
      chk("held_c1_wb_req", 32'(bus_if.wb_req), 32'd0);
      step();
      chk("held_c2_wb_req", 32'(bus_if.wb_req), 32'd1);
      chk("held_c2_wb_way", 32'(bus_if.wb_way), 32'd7);
      bus_if.miss_req = 1'b0;
      step();
      chk("held_c3_wb_req", 32'(bus_if.wb_req), 32'd0);
      chk("held_c3_alloc_valid", 32'(bus_if.alloc_valid), 32'd1);
      bus_if.wb_ack = 1'b0;
      step();
      chk("held_c4_busy", 32'(bus_if.busy), 32'd0);
      chk("held_c4_blk", 32'(bus_if.blk_accessed_main), 32'd7);

      // Asynchronous reset while waiting for a writeback.
      bus_if.way_dirty = 8'h04;
      bus_if.lru_replacement_proc = 3'd2;
      bus_if.miss_index = 10'h111;
      bus_if.miss_req   = 1'b1;
      step();
      step();
      chk("rstwb_c2_wb_req", 32'(bus_if.wb_req), 32'd1);
      bus_if.miss_req = 1'b0;
      #2;
      rst_b = 1'b0;
      #1;
      chk("rstwb_async_wb_req", 32'(bus_if.wb_req), 32'd0);
      chk("rstwb_async_busy", 32'(bus_if.busy), 32'd0);
      chk("rstwb_async_blk", 32'(bus_if.blk_accessed_main), 32'd0);
      chk("rstwb_async_index", 32'(bus_if.index_proc), 32'd0);
      step();
      rst_b = 1'b1;
      step();
      bus_if.wb_ack = 1'b1;
      step();
      bus_if.wb_ack = 1'b0;
      step();
      chk("rstwb_post_busy", 32'(bus_if.busy), 32'd0);
      chk("rstwb_post_wb_req", 32'(bus_if.wb_req), 32'd0);
      chk("rstwb_post_alloc_valid", 32'(bus_if.alloc_valid), 32'd0);

      // miss_req held across miss_ack with a new index: second miss starts from IDLE.
      bus_if.way_dirty = 8'h00;
      bus_if.lru_replacement_proc = 3'd1;
      bus_if.miss_index = 10'h0AA;
      bus_if.miss_req   = 1'b1;
      push(3'd1, 10'h0AA);
      step();
      step();
      chk("b2b_c2_alloc_valid", 32'(bus_if.alloc_valid), 32'd1);
      bus_if.miss_index = 10'h155;
      bus_if.lru_replacement_proc = 3'd4;
      push(3'd4, 10'h155);
      step();
      chk("b2b_c3_index", 32'(bus_if.index_proc), 32'h0AA);
      chk("b2b_c3_busy", 32'(bus_if.busy), 32'd0);
      step();
      chk("b2b_c4_index", 32'(bus_if.index_proc), 32'h155);
      chk("b2b_c4_busy", 32'(bus_if.busy), 32'd1);
      bus_if.miss_req = 1'b0;
      step();
      chk("b2b_c5_alloc_valid", 32'(bus_if.alloc_valid), 32'd1);
      step();
      chk("b2b_c6_blk", 32'(bus_if.blk_accessed_main), 32'd4);
      step();
      step();
      chk("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
